// File: rtl/axicb_cpl_pkg.sv
// axicb_cpl_pkg: shared types and field layout for the crossbar completion sequencer.
package axicb_cpl_pkg;
  typedef enum logic [1:0] {IDLE, FWD, MR} state_e;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] DECERR = 2'b11;
  localparam int ID_OFF = 0;
  function automatic int resp_off(input int id_w);
    return ID_OFF + id_w;
  endfunction
endpackage

// File: rtl/axicb_cpl_mr_gen.sv
// axicb_cpl_mr_gen: beat counter, last flag and DECERR payload for misrouted completions.
module axicb_cpl_mr_gen
  import axicb_cpl_pkg::*;
#(
  parameter int RD_PATH = 1,
  parameter int AXI_ID_W = 8,
  parameter int CCH_W = 8,
  parameter logic [1:0] MR_RESP = DECERR
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic [7:0]          len_i,
  input  logic [AXI_ID_W-1:0] id_i,
  input  logic                hs_i,
  output logic                last_o,
  output logic [CCH_W-1:0]    payload_o
);
  localparam int FW = resp_off(AXI_ID_W) + 2;
  logic [7:0] cnt_q, cnt_d, len_q;
  logic [AXI_ID_W-1:0] id_q;
  logic [FW-1:0] fld;
  assign last_o = (RD_PATH != 0) ? (cnt_q == len_q) : 1'b1;
  // 8-bit wrap on the final beat of ALEN=255 is intentional: the last compare clears it first
  assign cnt_d = load_i ? '0 : hs_i ? (last_o ? '0 : cnt_q + 8'd1) : cnt_q;
  assign fld = {MR_RESP, id_q};
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      len_q <= '0;
      id_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (load_i) begin
        len_q <= len_i;
        id_q <= id_i;
      end
    end
  end
  generate
    if (CCH_W > FW) begin : g_pad
      assign payload_o = {{(CCH_W-FW){1'b0}}, fld};
    end else begin : g_trunc
      assign payload_o = fld[CCH_W-1:0];
    end
  endgenerate
endmodule

// File: rtl/axicb_cpl_sequencer.sv
// axicb_cpl_sequencer: locks one granted slave per burst and forwards it, or emits a DECERR
// completion for misrouted IDs, returning arbiter enable and recreated last to the tracker.
module axicb_cpl_sequencer
  import axicb_cpl_pkg::*;
#(
  parameter int RD_PATH = 1,
  parameter int AXI_ID_W = 8,
  parameter int SLV_NB = 4,
  parameter int CCH_W = 8,
  parameter logic [1:0] MR_RESP = DECERR
) (
  input  logic                    aclk,
  input  logic                    srst,
  input  logic [SLV_NB-1:0]       g_grant,
  input  logic                    g_mr,
  input  logic [7:0]              g_len,
  input  logic [AXI_ID_W-1:0]     g_id,
  output logic                    g_en,
  output logic                    mr_last,
  input  logic [SLV_NB-1:0]       s_valid,
  output logic [SLV_NB-1:0]       s_ready,
  input  logic [SLV_NB-1:0]       s_last,
  input  logic [CCH_W*SLV_NB-1:0] s_ch,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic [CCH_W-1:0]        m_ch,
  output logic                    busy
);
  state_e state_q;
  logic [SLV_NB-1:0] grant_q;
  logic [CCH_W-1:0] fwd_ch, mr_ch;
  logic mr_lst, in_fwd, in_mr;
  assign in_fwd = state_q == FWD;
  assign in_mr = state_q == MR;
  always_comb begin
    fwd_ch = '0;
    for (int i = 0; i < SLV_NB; i++) fwd_ch = fwd_ch | (grant_q[i] ? s_ch[i*CCH_W +: CCH_W] : '0);
  end
  assign m_valid = in_fwd ? |(grant_q & s_valid) : in_mr;
  assign m_last = in_fwd ? |(grant_q & s_last) : in_mr & mr_lst;
  assign m_ch = in_fwd ? fwd_ch : in_mr ? mr_ch : '0;
  assign s_ready = (in_fwd && m_ready) ? grant_q : '0;
  assign mr_last = in_mr & mr_lst;
  assign g_en = m_valid & m_ready & m_last;
  assign busy = state_q != IDLE;
  // Misroute is checked first so a DECERR is never starved by a ready slave
  always_ff @(posedge aclk) begin
    if (srst) begin
      state_q <= IDLE;
      grant_q <= '0;
    end else if (state_q == IDLE) begin
      if (g_mr) state_q <= MR;
      else if (|(g_grant & s_valid)) begin
        state_q <= FWD;
        grant_q <= g_grant;
      end
    end else if (g_en) state_q <= IDLE;
  end
  axicb_cpl_mr_gen #(
    .RD_PATH(RD_PATH), .AXI_ID_W(AXI_ID_W), .CCH_W(CCH_W), .MR_RESP(MR_RESP)
  ) u_mr (
    .clk(aclk), .rst(srst), .load_i(state_q == IDLE && g_mr), .len_i(g_len), .id_i(g_id),
    .hs_i(in_mr && m_ready), .last_o(mr_lst), .payload_o(mr_ch)
  );
  a_grant_onehot: assert property (@(posedge aclk) disable iff (srst) $onehot0(g_grant));
  a_valid_stable: assert property (@(posedge aclk) disable iff (srst)
    (in_fwd && m_valid && !m_ready) |=> m_valid);
  a_mr_first: assert property (@(posedge aclk) disable iff (srst)
    (state_q == IDLE && g_mr) |=> in_mr);
endmodule
